// File: rtl/fetch_if_id_stage.sv
// Instruction-fetch stage with IF/ID pipeline register for the COEN122 core.
// Issues req/ack fetches, latches {pc, instr}, and handles stall, flush and a one-entry hold buffer.
module fetch_if_id_stage #(
  parameter int              PC_W     = 32,
  parameter logic [PC_W-1:0] RESET_PC = '0,
  parameter int              PC_STEP  = 1
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req,
  output logic [PC_W-1:0] imem_addr,
  input  logic [31:0]     imem_rdata,
  input  logic            imem_ack,
  input  logic            stall_id,
  input  logic            redirect,
  input  logic [PC_W-1:0] redirect_pc,
  output logic            id_valid,
  output logic [PC_W-1:0] id_pc,
  output logic [31:0]     id_instr,
  output logic [3:0]      id_opcode,
  output logic [5:0]      id_rd,
  output logic [5:0]      id_rs,
  output logic [5:0]      id_rt,
  output logic [11:0]     id_imm12
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_HOLD  = 2'd2;
  localparam logic [1:0] S_DRAIN = 2'd3;

  logic [1:0]      state_q, state_d;
  logic [PC_W-1:0] fetch_addr_q, fetch_addr_d;
  logic [PC_W-1:0] target_q, target_d;
  logic [PC_W-1:0] buf_pc_q, buf_pc_d;
  logic [31:0]     buf_instr_q, buf_instr_d;
  logic            id_valid_q, id_valid_d;
  logic [PC_W-1:0] id_pc_q, id_pc_d;
  logic [31:0]     id_instr_q, id_instr_d;
  logic [PC_W-1:0] pc_inc;

  assign pc_inc = fetch_addr_q + PC_W'(PC_STEP);

  always_comb begin
    state_d      = state_q;
    fetch_addr_d = fetch_addr_q;
    target_d     = target_q;
    buf_pc_d     = buf_pc_q;
    buf_instr_d  = buf_instr_q;
    id_valid_d   = id_valid_q;
    id_pc_d      = id_pc_q;
    id_instr_d   = id_instr_q;
    case (state_q)
      S_IDLE: state_d = S_FETCH;
      S_FETCH: begin
        // Flush beats stall; an un-acked request must keep its address until it drains.
        if (redirect) begin
          id_valid_d = 1'b0;
          if (imem_ack) begin
            fetch_addr_d = redirect_pc;
          end else begin
            target_d = redirect_pc;
            state_d  = S_DRAIN;
          end
        end else if (imem_ack) begin
          fetch_addr_d = pc_inc;
          if (!stall_id) begin
            id_valid_d = 1'b1;
            id_pc_d    = fetch_addr_q;
            id_instr_d = imem_rdata;
          end else begin
            buf_pc_d    = fetch_addr_q;
            buf_instr_d = imem_rdata;
            state_d     = S_HOLD;
          end
        end else if (!stall_id) begin
          id_valid_d = 1'b0;
        end
      end
      S_HOLD: begin
        if (redirect) begin
          fetch_addr_d = redirect_pc;
          id_valid_d   = 1'b0;
          state_d      = S_FETCH;
        end else if (!stall_id) begin
          id_valid_d = 1'b1;
          id_pc_d    = buf_pc_q;
          id_instr_d = buf_instr_q;
          state_d    = S_FETCH;
        end
      end
      S_DRAIN: begin
        id_valid_d = 1'b0;
        if (imem_ack) begin
          fetch_addr_d = redirect ? redirect_pc : target_q;
          state_d      = S_FETCH;
        end else if (redirect) begin
          target_d = redirect_pc;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      fetch_addr_q <= RESET_PC;
      target_q     <= '0;
      buf_pc_q     <= '0;
      buf_instr_q  <= '0;
      id_valid_q   <= 1'b0;
      id_pc_q      <= '0;
      id_instr_q   <= '0;
    end else begin
      state_q      <= state_d;
      fetch_addr_q <= fetch_addr_d;
      target_q     <= target_d;
      buf_pc_q     <= buf_pc_d;
      buf_instr_q  <= buf_instr_d;
      id_valid_q   <= id_valid_d;
      id_pc_q      <= id_pc_d;
      id_instr_q   <= id_instr_d;
    end
  end

  assign imem_req  = (state_q == S_FETCH) || (state_q == S_DRAIN);
  assign imem_addr = fetch_addr_q;
  assign id_valid  = id_valid_q;
  assign id_pc     = id_pc_q;
  assign id_instr  = id_instr_q;
  assign id_opcode = id_instr_q[31:28];
  assign id_rd     = id_instr_q[27:22];
  assign id_rs     = id_instr_q[21:16];
  assign id_rt     = id_instr_q[15:10];
  assign id_imm12  = id_instr_q[11:0];

endmodule

// File: tb/tb_fetch_if_id_stage.sv
// Scoreboarded bench for fetch_if_id_stage: expected {pc, instr} pushed as fetches are driven,
// popped whenever the IF/ID register loads a live instruction.
module tb_fetch_if_id_stage;

  logic        clk = 1'b0;
  logic        rst, imem_req, imem_ack, stall_id, redirect, id_valid;
  logic [31:0] imem_addr, imem_rdata, redirect_pc, id_pc, id_instr;
  logic [3:0]  id_opcode;
  logic [5:0]  id_rd, id_rs, id_rt;
  logic [11:0] id_imm12;
  logic        ack_in;
  logic        stall_at_edge = 1'b0;

  int n_chk  = 0;
  int n_fail = 0;
  logic [63:0] sb_q[$];

  always #5 clk = ~clk;

  fetch_if_id_stage dut (
    .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rdata(imem_rdata), .imem_ack(imem_ack), .stall_id(stall_id),
    .redirect(redirect), .redirect_pc(redirect_pc), .id_valid(id_valid),
    .id_pc(id_pc), .id_instr(id_instr), .id_opcode(id_opcode), .id_rd(id_rd),
    .id_rs(id_rs), .id_rt(id_rt), .id_imm12(id_imm12)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a == 32'h7) ? 32'hA0C3_1FFF : 32'h1000_0000 + a;
  endfunction

  assign imem_ack   = ack_in;
  assign imem_rdata = mem_word(imem_addr);

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  task automatic push_exp(input logic [31:0] a);
    sb_q.push_back({a, mem_word(a)});
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // An unstalled edge either loads a live instruction or a bubble.
  always @(posedge clk) stall_at_edge = stall_id;

  always @(negedge clk) begin
    if (!rst && !stall_at_edge && id_valid) begin
      if (sb_q.size() == 0) begin
        chk("sb_underflow", sb_q.size(), 1);
      end else begin
        logic [63:0] e;
        e = sb_q.pop_front();
        chk("sb_pc", id_pc, e[63:32]);
        chk("sb_instr", id_instr, e[31:0]);
      end
    end
  end

  initial begin
    rst = 1'b1; ack_in = 1'b0; stall_id = 1'b0; redirect = 1'b0; redirect_pc = '0;
    step(); step();
    chk("rst_req", imem_req, 0);
    chk("rst_valid", id_valid, 0);
    chk("rst_pc", id_pc, 0);
    chk("rst_instr", id_instr, 0);
    chk("rst_addr", imem_addr, 0);
    chk("rst_imm", id_imm12, 0);

    // zero-wait streaming from RESET_PC
    rst = 1'b0; ack_in = 1'b1;
    step();
    for (int i = 0; i < 5; i++) begin
      chk("stream_addr", imem_addr, i);
      chk("stream_req", imem_req, 1);
      if (i == 1) begin
        chk("first_opcode", id_opcode, 4'h1);
        chk("first_imm", id_imm12, 12'h000);
      end
      push_exp(i);
      step();
    end

    // stall 3 cycles with ack at addr 5
    chk("pre_stall_pc", id_pc, 4);
    stall_id = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("hold_req", imem_req, 0);
      chk("hold_pc", id_pc, 4);
      chk("hold_valid", id_valid, 1);
    end
    stall_id = 1'b0;
    push_exp(5);
    step();
    chk("resume_addr", imem_addr, 6);
    chk("resume_req", imem_req, 1);
    push_exp(6); step();
    push_exp(7); step();
    chk("dec_opcode", id_opcode, 4'hA);
    chk("dec_rd", id_rd, 6'h03);
    chk("dec_rs", id_rs, 6'h03);
    chk("dec_rt", id_rt, 6'h07);
    chk("dec_imm", id_imm12, 12'hFFF);
    chk("dec_valid", id_valid, 1);

    // redirect with an outstanding un-acked request at 8
    ack_in = 1'b0; redirect = 1'b1; redirect_pc = 32'h40;
    step();
    redirect = 1'b0;
    for (int i = 0; i < 2; i++) begin
      chk("drain_addr", imem_addr, 8);
      chk("drain_req", imem_req, 1);
      chk("drain_valid", id_valid, 0);
      step();
    end
    ack_in = 1'b1;
    step();
    chk("redir_addr", imem_addr, 32'h40);
    chk("redir_valid", id_valid, 0);
    push_exp(32'h40); step();
    chk("redir_pc", id_pc, 32'h40);

    // redirect while in HOLD with stall asserted
    stall_id = 1'b1;
    step();
    redirect = 1'b1; redirect_pc = 32'h80;
    step();
    chk("holdredir_valid", id_valid, 0);
    chk("holdredir_addr", imem_addr, 32'h80);
    redirect = 1'b0; stall_id = 1'b0;
    push_exp(32'h80); step();

    // bubble: no ack, no stall
    ack_in = 1'b0;
    step();
    chk("bubble_valid", id_valid, 0);
    chk("bubble_addr", imem_addr, 32'h81);

    // acked redirect to all-ones, then wrap to 0
    ack_in = 1'b1; redirect = 1'b1; redirect_pc = 32'hFFFF_FFFF;
    step();
    redirect = 1'b0;
    chk("wrap_pre", imem_addr, 32'hFFFF_FFFF);
    push_exp(32'hFFFF_FFFF); step();
    chk("wrap_addr", imem_addr, 0);

    // latest redirect in DRAIN wins
    ack_in = 1'b0; redirect = 1'b1; redirect_pc = 32'h100;
    step();
    redirect_pc = 32'h200;
    step();
    redirect = 1'b0; ack_in = 1'b1;
    step();
    chk("drain_latest", imem_addr, 32'h200);

    // reset mid-DRAIN with an ack in flight
    ack_in = 1'b0; redirect = 1'b1; redirect_pc = 32'h300;
    step();
    redirect = 1'b0; rst = 1'b1; ack_in = 1'b1;
    step();
    chk("mrst_req", imem_req, 0);
    chk("mrst_valid", id_valid, 0);
    rst = 1'b0;
    step();
    chk("mrst_fetch_req", imem_req, 1);
    chk("mrst_fetch_addr", imem_addr, 0);
    ack_in = 1'b0;
    step();

    chk("sb_leftover", sb_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
